nrd_div_ctrl: RTL and testbench

- Sequencing controller for an 8-bit unsigned non-restoring divider built around the team's `parallel_adder_subtractor` datapath.
- Owns the partial-remainder register A (9-bit, two's complement), quotient register Q (8-bit) and divisor register M (8-bit).
- Drives the adder's operation select once per iteration and runs a final remainder-correction step.
- Presents a valid/ready request and response interface to the surrounding system.

---
 rtl/nrd_div_ctrl_pkg.sv | 24 ++
 rtl/nrd_div_ctrl_parallel_adder_subtractor.sv | 22 ++
 rtl/nrd_div_ctrl.sv | 143 ++++++++++++++
 tb/tb_nrd_div_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/nrd_div_ctrl_pkg.sv
// Shared definitions for the non-restoring divider controller.
//   - NRD_W / NRD_ITERS : operand width and iteration count (fixed at 8)
//   - nrd_state_e       : FSM encodings ST_IDLE, ST_ITER, ST_FIX, ST_DONE
//   - OP_ADD / OP_SUB   : parallel_adder_subtractor operation_type values
//   - nrd_mag()         : two's complement magnitude (used when NRD_SIGNED_EN)
package nrd_div_ctrl_pkg;
  localparam int NRD_W     = 8;
  localparam int NRD_ITERS = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } nrd_state_e;

  localparam logic OP_ADD = 1'b1;
  localparam logic OP_SUB = 1'b0;

  // -128 maps to 8'h80, which is still correct as an unsigned magnitude.
  function automatic logic [NRD_W-1:0] nrd_mag(input logic [NRD_W-1:0] v);
    return v[NRD_W-1] ? NRD_W'(-v) : v;
  endfunction
endpackage

// File: rtl/nrd_div_ctrl_parallel_adder_subtractor.sv
// parallel_adder_subtractor: 9-bit two's complement add/subtract datapath.
// Ports:
//   sign_in, x      : 9-bit operand {sign_in, x}
//   y               : 8-bit unsigned operand, zero-extended
//   operation_type  : OP_ADD (1) adds y, OP_SUB (0) subtracts y
//   sign_out,result : 9-bit result modulo 2^9
module parallel_adder_subtractor
  import nrd_div_ctrl_pkg::*;
(
  input  logic             sign_in,
  input  logic [NRD_W-1:0] x,
  input  logic [NRD_W-1:0] y,
  input  logic             operation_type,
  output logic             sign_out,
  output logic [NRD_W-1:0] result
);
  logic [NRD_W:0] sum;

  assign sum = (operation_type == OP_ADD) ? ({sign_in, x} + {1'b0, y})
                                          : ({sign_in, x} - {1'b0, y});
  assign {sign_out, result} = sum;
endmodule

// File: rtl/nrd_div_ctrl.sv
// nrd_div_ctrl: sequencing controller for an 8-bit non-restoring divider.
// Owns A (9-bit partial remainder), Q (quotient) and M (divisor); time-shares
// one parallel_adder_subtractor between the ITER and FIX states.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   in_valid/in_ready        : request handshake with dividend, divisor
//   out_valid/out_ready      : response handshake with quotient, remainder,
//                              div_by_zero, ovf
// Optional macro NRD_SIGNED_EN: two's complement operands, ovf on -128/-1.
// Without it the divider is unsigned and ovf is tied 0.
module nrd_div_ctrl
  import nrd_div_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NRD_W-1:0] dividend,
  input  logic [NRD_W-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NRD_W-1:0] quotient,
  output logic [NRD_W-1:0] remainder,
  output logic             div_by_zero,
  output logic             ovf
);
  localparam logic [2:0] LAST_ITER = 3'(NRD_ITERS - 1);

  nrd_state_e       state;
  logic [NRD_W:0]   a_q;
  logic [NRD_W-1:0] q_q;
  logic [NRD_W-1:0] m_q;
  logic [2:0]       count;

  logic             add_sign_in, add_op, add_sign_out;
  logic [NRD_W-1:0] add_x, add_result;
  logic [NRD_W:0]   a_fix;

  // FIX adds M back to a negative A; ITER works on the shifted {A,Q}, whose
  // new sign is A[7] and whose low bit comes from Q[7].
  always_comb begin
    add_sign_in = a_q[NRD_W-1];
    add_x       = {a_q[NRD_W-2:0], q_q[NRD_W-1]};
    add_op      = a_q[NRD_W] ? OP_ADD : OP_SUB;
    if (state == ST_FIX) begin
      add_sign_in = a_q[NRD_W];
      add_x       = a_q[NRD_W-1:0];
      add_op      = OP_ADD;
    end
  end

  parallel_adder_subtractor u_addsub (
    .sign_in        (add_sign_in),
    .x              (add_x),
    .y              (m_q),
    .operation_type (add_op),
    .sign_out       (add_sign_out),
    .result         (add_result)
  );

  assign a_fix = a_q[NRD_W] ? {add_sign_out, add_result} : a_q;

`ifdef NRD_SIGNED_EN
  logic sign_a, sign_b, ovf_q;
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      a_q         <= '0;
      q_q         <= '0;
      m_q         <= '0;
      count       <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef NRD_SIGNED_EN
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: if (in_valid) begin
          a_q      <= '0;
          count    <= '0;
          in_ready <= 1'b0;
`ifdef NRD_SIGNED_EN
          q_q      <= nrd_mag(dividend);
          m_q      <= nrd_mag(divisor);
          sign_a   <= dividend[NRD_W-1];
          sign_b   <= divisor[NRD_W-1];
          ovf_q    <= 1'b0;
`else
          q_q      <= dividend;
          m_q      <= divisor;
`endif
          if (divisor == '0) begin
            state       <= ST_DONE;
            out_valid   <= 1'b1;
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
          end else begin
            state <= ST_ITER;
          end
        end
        ST_ITER: begin
          a_q   <= {add_sign_out, add_result};
          q_q   <= {q_q[NRD_W-2:0], ~add_sign_out};
          count <= count + 3'd1;
          if (count == LAST_ITER) state <= ST_FIX;
        end
        ST_FIX: begin
          a_q         <= a_fix;
`ifdef NRD_SIGNED_EN
          quotient    <= (sign_a ^ sign_b) ? NRD_W'(-q_q) : q_q;
          remainder   <= sign_a ? NRD_W'(-a_fix[NRD_W-1:0]) : a_fix[NRD_W-1:0];
          // A magnitude-128 quotient with like signs only arises from -128/-1.
          ovf_q       <= ~(sign_a ^ sign_b) && (q_q == 8'h80);
`else
          quotient    <= q_q;
          remainder   <= a_fix[NRD_W-1:0];
`endif
          div_by_zero <= 1'b0;
          out_valid   <= 1'b1;
          state       <= ST_DONE;
        end
        ST_DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nrd_div_ctrl.sv
module tb_nrd_div_ctrl;
  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, out_valid, out_ready, div_by_zero, ovf;
  logic [7:0] dividend, divisor, quotient, remainder;
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  nrd_div_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
    .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .ovf(ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and step through the accept edge.
  task automatic accept(input logic [7:0] a, input logic [7:0] b);
    in_valid = 1'b1; dividend = a; divisor = b;
    tick();
    in_valid = 1'b0;
  endtask

  // Latency counts the accept edge as 1; also reports whether in_ready rose.
  task automatic wait_result(output int lat, output bit rdy_seen);
    lat = 1; rdy_seen = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready) rdy_seen = 1'b1;
      tick();
      lat++;
    end
    if (in_ready) rdy_seen = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; dividend = 8'd9; divisor = 8'd3; out_ready = 1'b0;
    tick(); tick();
    in_valid = 1'b0; rst = 1'b0;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if ({quotient, remainder, div_by_zero, ovf} !== 18'd0)
      begin n_err++; $display("FAIL reset_outputs got q=%h r=%h dz=%b ovf=%b want 0", quotient, remainder, div_by_zero, ovf); end
    tick();
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      begin n_err++; $display("FAIL reset_wins_accept got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
  endtask

  task automatic test_basic();
    int lat; bit rdy;
    out_ready = 1'b1;
    accept(8'd100, 8'd7);
    wait_result(lat, rdy);
    n_cmp++; if (lat !== 10) begin n_err++; $display("FAIL basic_latency got %0d want 10", lat); end
    n_cmp++; if (rdy !== 1'b0) begin n_err++; $display("FAIL basic_in_ready_busy got %b want 0", rdy); end
    n_cmp++; if (quotient !== 8'd14 || remainder !== 8'd2 || div_by_zero !== 1'b0)
      begin n_err++; $display("FAIL basic_100_7 got q=%0d r=%0d dz=%b want 14 2 0", quotient, remainder, div_by_zero); end
    tick();
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin n_err++; $display("FAIL basic_retire got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_back_to_back();
    int lat; bit rdy;
    out_ready = 1'b0;
    accept(8'd255, 8'd1);
    in_valid = 1'b1; dividend = 8'd3; divisor = 8'd200;
    wait_result(lat, rdy);
    n_cmp++; if (quotient !== 8'd255 || remainder !== 8'd0 || rdy !== 1'b0)
      begin n_err++; $display("FAIL b2b_first got q=%0d r=%0d rdy=%b want 255 0 0", quotient, remainder, rdy); end
    tick();
    n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0)
      begin n_err++; $display("FAIL b2b_hold got out_valid=%b in_ready=%b want 1/0", out_valid, in_ready); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin n_err++; $display("FAIL b2b_handshake got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_result(lat, rdy);
    n_cmp++; if (lat !== 10 || quotient !== 8'd0 || remainder !== 8'd3)
      begin n_err++; $display("FAIL b2b_second got lat=%0d q=%0d r=%0d want 10 0 3", lat, quotient, remainder); end
    tick();
  endtask

  task automatic test_div_zero();
    int lat; bit rdy;
    out_ready = 1'b1;
    accept(8'd5, 8'd0);
    wait_result(lat, rdy);
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL dz_latency got %0d want 1", lat); end
    n_cmp++; if (quotient !== 8'hFF || remainder !== 8'd5 || div_by_zero !== 1'b1)
      begin n_err++; $display("FAIL dz_result got q=%h r=%0d dz=%b want ff 5 1", quotient, remainder, div_by_zero); end
    tick();
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin n_err++; $display("FAIL dz_retire got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_backpressure();
    int lat; bit rdy; int bad;
    out_ready = 1'b0;
    accept(8'd200, 8'd13);
    wait_result(lat, rdy);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 8'd15 || remainder !== 8'd5) bad++;
      tick();
    end
    n_cmp++; if (lat !== 10 || bad !== 0)
      begin n_err++; $display("FAIL bp_stable got lat=%0d bad_cycles=%0d want 10 0", lat, bad); end
    out_ready = 1'b1;
    tick();
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin n_err++; $display("FAIL bp_release got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid();
    int lat; bit rdy; bit seen;
    out_ready = 1'b1;
    accept(8'd50, 8'd3);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      begin n_err++; $display("FAIL rstmid_idle got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL rstmid_no_result got %b want 0", seen); end
    accept(8'd9, 8'd2);
    wait_result(lat, rdy);
    n_cmp++; if (lat !== 10 || quotient !== 8'd4 || remainder !== 8'd1)
      begin n_err++; $display("FAIL rstmid_fresh got lat=%0d q=%0d r=%0d want 10 4 1", lat, quotient, remainder); end
    tick();
  endtask

`ifdef NRD_SIGNED_EN
  task automatic test_signed();
    int lat; bit rdy;
    out_ready = 1'b1;
    accept(8'h9C, 8'd7);
    wait_result(lat, rdy);
    n_cmp++; if (quotient !== 8'hF2 || remainder !== 8'hFE || ovf !== 1'b0)
      begin n_err++; $display("FAIL signed_m100_7 got q=%h r=%h ovf=%b want f2 fe 0", quotient, remainder, ovf); end
    tick();
    accept(8'h80, 8'hFF);
    wait_result(lat, rdy);
    n_cmp++; if (quotient !== 8'h80 || remainder !== 8'h00 || ovf !== 1'b1)
      begin n_err++; $display("FAIL signed_ovf got q=%h r=%h ovf=%b want 80 00 1", quotient, remainder, ovf); end
    tick();
  endtask
`endif

  initial begin
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
    test_reset();
    test_basic();
    test_div_zero();
    test_reset_mid();
`ifdef NRD_SIGNED_EN
    test_signed();
`else
    test_back_to_back();
    test_backpressure();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
